// File: rtl/pulse_framer_if.sv
// pulse_framer_if: sample stream with a 128-bit CVITA header sideband
interface pulse_framer_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] tdata;
  logic [127:0]     tuser;
  logic             tvalid;
  logic             tlast;
  logic             tready;
  modport master(output tdata, tuser, tvalid, tlast, input tready);
  modport slave(input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pulse_framer.sv
// pulse_framer: cuts a timed sample stream into fixed-length pulses, one output packet each
module pulse_framer #(
  parameter int MAX_PULSE_SIZE = 8192,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [31:0]   pulse_size,
  input  logic [31:0]   num_avg,
  output logic [31:0]   pulse_count,
  output logic          frame_err,
  output logic          short_pulse,
  pulse_framer_if.slave  up,
  pulse_framer_if.master down
);
  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;
  state_t       state;
  logic         sop, timed_sop, start, bad, fwd, acc, nat_last, eob_end, unused_hdr;
  logic [31:0]  idx, size_q, navg_q, size_now, navg_now, navg_in;
  logic [11:0]  seq;
  logic [63:0]  time_q, time_now;
  logic [127:0] hdr_q, hdr_now;
  // The first sample of a pulse is built and forwarded in the same cycle, so the header is muxed live
  always_comb begin
    timed_sop   = sop & up.tuser[125];
    start       = (state == IDLE && timed_sop) || (state == RUN && idx == 32'd0);
    bad         = pulse_size == 32'd0 || pulse_size > 32'(MAX_PULSE_SIZE);
    fwd         = (state == RUN || (state == IDLE && timed_sop)) && !(start && bad);
    up.tready   = fwd ? down.tready : 1'b1;
    acc         = up.tvalid & up.tready;
    navg_in     = num_avg == 32'd0 ? 32'd1 : num_avg;
    size_now    = start ? pulse_size : size_q;
    navg_now    = start ? navg_in : navg_q;
    nat_last    = idx == size_now - 32'd1;
    eob_end     = up.tlast & up.tuser[124];
    time_now    = timed_sop ? up.tuser[63:0] : time_q;
    hdr_now     = {up.tuser[127:126], 1'b1, pulse_count == navg_now - 32'd1, seq,
                   {pulse_size[13:0], 2'b00} + 16'd16, up.tuser[95:64], time_now};
    unused_hdr  = ^up.tuser[123:96];
    down.tdata  = up.tdata[WIDTH-1:0];
    down.tvalid = fwd & up.tvalid;
    down.tlast  = fwd & (nat_last | eob_end);
    down.tuser  = start ? hdr_now : hdr_q;
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= IDLE;
      sop         <= 1'b1;
      idx         <= '0;
      size_q      <= '0;
      navg_q      <= 32'd1;
      seq         <= '0;
      pulse_count <= '0;
      frame_err   <= 1'b0;
      short_pulse <= 1'b0;
      time_q      <= '0;
      hdr_q       <= '0;
    end else begin
      short_pulse <= 1'b0;
      if (acc) begin
        sop    <= up.tlast;
        time_q <= time_now + 64'd1;
      end
      if (acc && start && bad) begin
        frame_err <= 1'b1;
        state     <= DROP;
      end else if (acc && fwd) begin
        if (start) begin
          size_q <= pulse_size;
          navg_q <= navg_in;
          hdr_q  <= hdr_now;
          state  <= RUN;
        end
        if (nat_last || eob_end) begin
          idx <= '0;
          seq <= seq + 12'd1;
          // A natural end wins over an input eob landing on the same sample
          if (nat_last)
            pulse_count <= pulse_count >= navg_now - 32'd1 ? 32'd0 : pulse_count + 32'd1;
          else begin
            pulse_count <= '0;
            short_pulse <= 1'b1;
            state       <= IDLE;
          end
        end else
          idx <= idx + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pulse_framer.sv
// tb_pulse_framer: directed scoreboard bench for pulse_framer
module tb_pulse_framer;
  logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [31:0] pulse_size = 32'd4, num_avg = 32'd3, pulse_count;
  logic        frame_err, short_pulse;
  pulse_framer_if up();
  pulse_framer_if down();
  pulse_framer dut (.clk(clk), .reset(reset), .clear(clear), .pulse_size(pulse_size),
                    .num_avg(num_avg), .pulse_count(pulse_count), .frame_err(frame_err),
                    .short_pulse(short_pulse), .up(up), .down(down));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] d; logic [127:0] u; logic l;} exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0, vcount = 0, v0;
  bit gaps = 0;
  int rdy_mode = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  function automatic logic [127:0] ih(bit ht, bit eob, logic [63:0] t);
    return {2'b01, ht, eob, 12'hABC, 16'h1234, 32'hAABBCCDD, t};
  endfunction
  function automatic logic [127:0] oh(bit eob, logic [11:0] s, logic [15:0] len, logic [63:0] t);
    return {2'b01, 1'b1, eob, s, len, 32'hAABBCCDD, t};
  endfunction
  function automatic void push(logic [31:0] d, logic [127:0] u, logic l);
    exp_t x;
    x.d = d; x.u = u; x.l = l;
    q.push_back(x);
  endfunction
  task automatic beat(input logic [31:0] d, input logic [127:0] u, input logic l);
    int n;
    n = 0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    up.tvalid = 1'b1; up.tdata = d; up.tuser = u; up.tlast = l;
    forever begin
      #1;
      if (up.tready) break;
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("accept_timeout", 128'd0, 128'd1);
        break;
      end
    end
    @(negedge clk);
    up.tvalid = 1'b0; up.tdata = '0; up.tuser = '0; up.tlast = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    down.tready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode[0];
  end
  initial forever begin
    exp_t x;
    @(negedge clk);
    #2;
    if (down.tvalid) vcount++;
    if (down.tvalid && down.tready) begin
      if (q.size() == 0) chk("unexpected_beat", 128'(down.tdata), 128'hx);
      else begin
        x = q.pop_front();
        chk("o_tdata", 128'(down.tdata), 128'(x.d));
        chk("o_tuser", down.tuser, x.u);
        chk("o_tlast", 128'(down.tlast), 128'(x.l));
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    up.tvalid = 0; up.tdata = 0; up.tuser = 0; up.tlast = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_pulse_count", 128'(pulse_count), 0);
    chk("rst_frame_err", 128'(frame_err), 0);
    chk("rst_short_pulse", 128'(short_pulse), 0);
    chk("rst_o_tvalid", 128'(down.tvalid), 0);
    chk("rst_o_tlast", 128'(down.tlast), 0);
    chk("rst_o_tuser", down.tuser, 0);
    chk("rst_i_tready", 128'(up.tready), 1);
    rdy_mode = 1;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      push(100 + k, oh(k / 4 == 2, 12'(k / 4), 16'd32, 64'(1000 + 4 * (k / 4))), k % 4 == 3);
      beat(100 + k, ih(1, 0, 1000), k == 11);
    end
    #1 chk("t1_pulse_count", 128'(pulse_count), 0);
    pulse_size = 6; num_avg = 0;
    for (int k = 0; k < 12; k++) begin
      push(200 + k, oh(1, 12'(3 + k / 6), 16'd40, 64'(6 * (k / 6))), k % 6 == 5);
      beat(200 + k, ih(1, 0, 64'(4 * (k / 4))), k % 4 == 3);
    end
    #1 chk("t2_pulse_count", 128'(pulse_count), 0);
    pulse_size = 16; num_avg = 4; rdy_mode = 2; gaps = 1;
    for (int k = 0; k < 1024; k++) begin
      push(32'(k * 7919), oh((k / 16) % 4 == 3, 12'(5 + k / 16), 16'd80, 64'(5000 + 16 * (k / 16))), k % 16 == 15);
      beat(32'(k * 7919), ih(1, 0, 5000), k == 1023);
    end
    rdy_mode = 1; gaps = 0;
    @(negedge clk);
    #1 chk("t3_pulse_count", 128'(pulse_count), 0);
    chk("t3_queue_drained", 128'(q.size()), 0);
    pulse_size = 8; num_avg = 3;
    for (int k = 0; k < 8; k++) begin
      push(300 + k, oh(0, 69, 16'd48, 100), k == 7);
      beat(300 + k, ih(1, 0, 100), k == 7);
    end
    for (int k = 0; k < 6; k++) begin
      push(400 + k, oh(0, 70, 16'd48, 200), k == 5);
      beat(400 + k, ih(1, 1, 200), k == 5);
    end
    #1 chk("trunc_short_pulse", 128'(short_pulse), 1);
    chk("trunc_pulse_count", 128'(pulse_count), 0);
    rdy_mode = 0;
    @(negedge clk);
    #1 chk("trunc_short_pulse_clr", 128'(short_pulse), 0);
    chk("idle_i_tready", 128'(up.tready), 1);
    rdy_mode = 1;
    @(negedge clk);
    v0 = vcount;
    for (int k = 0; k < 3; k++) beat(500 + k, ih(0, 0, 0), k == 2);
    chk("untimed_sop_dropped", 128'(vcount - v0), 0);
    for (int k = 0; k < 8; k++) begin
      push(600 + k, oh(0, 71, 16'd48, 300), k == 7);
      beat(600 + k, ih(1, 0, 300), k == 7);
    end
    for (int k = 0; k < 8; k++) begin
      push(700 + k, oh(0, 72, 16'd48, 400), k == 7);
      beat(700 + k, ih(1, 1, 400), k == 7);
    end
    #1 chk("nat_eob_short_pulse", 128'(short_pulse), 0);
    chk("nat_eob_pulse_count", 128'(pulse_count), 2);
    clear = 1; @(negedge clk); clear = 0;
    #1 chk("clear_pulse_count", 128'(pulse_count), 0);
    pulse_size = 0; rdy_mode = 0;
    @(negedge clk);
    v0 = vcount;
    for (int k = 0; k < 4; k++) beat(800 + k, ih(1, 0, 0), k == 3);
    #1 chk("size0_frame_err", 128'(frame_err), 1);
    chk("size0_no_valid", 128'(vcount - v0), 0);
    chk("drop_i_tready", 128'(up.tready), 1);
    clear = 1; @(negedge clk); clear = 0;
    #1 chk("clear_frame_err", 128'(frame_err), 0);
    pulse_size = 8193;
    v0 = vcount;
    for (int k = 0; k < 4; k++) beat(820 + k, ih(1, 0, 0), k == 3);
    pulse_size = 4;
    for (int k = 0; k < 4; k++) beat(840 + k, ih(1, 0, 0), k == 3);
    #1 chk("oversize_frame_err", 128'(frame_err), 1);
    chk("oversize_no_valid", 128'(vcount - v0), 0);
    clear = 1; rdy_mode = 1; num_avg = 2;
    @(negedge clk); clear = 0;
    for (int k = 0; k < 8; k++) begin
      push(900 + k, oh(k / 4 == 1, 12'(k / 4), 16'd32, 64'(7 + 4 * (k / 4))), k % 4 == 3);
      beat(900 + k, ih(1, 0, 7), k == 7);
    end
    pulse_size = 1; num_avg = 1;
    for (int k = 0; k < 4097; k++) begin
      push(k, oh(1, 12'(2 + k), 16'd20, 64'(k)), 1'b1);
      beat(k, ih(1, 0, 0), k == 4096);
    end
    pulse_size = 8; num_avg = 3;
    for (int k = 0; k < 3; k++) begin
      push(50 + k, oh(0, 3, 16'd48, 50), 1'b0);
      beat(50 + k, ih(1, 0, 50), 1'b0);
    end
    reset = 1; @(negedge clk); reset = 0;
    #1 chk("mid_rst_pulse_count", 128'(pulse_count), 0);
    chk("mid_rst_short_pulse", 128'(short_pulse), 0);
    chk("mid_rst_o_tvalid", 128'(down.tvalid), 0);
    chk("mid_rst_o_tlast", 128'(down.tlast), 0);
    chk("mid_rst_o_tuser", down.tuser, 0);
    chk("mid_rst_i_tready", 128'(up.tready), 1);
    pulse_size = 4; num_avg = 1;
    for (int k = 0; k < 4; k++) begin
      push(60 + k, oh(1, 0, 16'd32, 9), k == 3);
      beat(60 + k, ih(1, 0, 9), k == 3);
    end
    @(negedge clk);
    chk("final_queue_drained", 128'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
